// File: rtl/sc_node_pkg.sv
// Shared definitions for the SmartConnect node egress endpoint.
package sc_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } sc_state_e;

    localparam int SC_AR_W = 174;
    localparam int SC_AW_W = 174;
    localparam int SC_W_W  = 592;
    localparam int SC_R_W  = 533;
    localparam int SC_B_W  = 7;

endpackage

// File: rtl/sc_node_egress_ram.sv
// Beat storage for the egress buffer: synchronous write, asynchronous read.
module sc_node_egress_ram #(
    parameter int WIDTH = 175,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sc_node_egress.sv
// SmartConnect node egress: grants credits, buffers arriving beats and
// presents them as a first-word fall-through valid/ready stream.
module sc_node_egress
    import sc_node_pkg::*;
#(
    parameter int PAYLD_WIDTH = 174,
    parameter int DEPTH       = 8,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic                   s_sc_aclk,
    input  logic                   s_sc_areset,
    input  logic                   s_sc_req,
    input  logic                   s_sc_info,
    input  logic                   s_sc_send,
    input  logic [PAYLD_WIDTH-1:0] s_sc_payld,
    output logic                   s_sc_recv,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [PAYLD_WIDTH-1:0] m_tdata,
    output logic                   m_tuser,
    output logic [CW-1:0]          outstanding,
    output logic [CW-1:0]          occupancy,
    output logic                   err_send_no_credit
);

    localparam int AW = $clog2(DEPTH);

    sc_state_e            state_q, state_d;
    logic [CW-1:0]        occ_q, occ_d;
    logic [CW-1:0]        out_q, out_d;
    logic [AW-1:0]        wptr_q, rptr_q;
    logic                 recv_q;
    logic                 err_q;

    logic [CW-1:0]        avail;
    logic                 avail_nz;
    logic                 grant;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic [PAYLD_WIDTH:0] rd_data;

    // Uses registered counters only, so a slot freed by a pop is seen one cycle later.
    assign avail    = CW'(DEPTH) - occ_q - out_q;
    assign avail_nz = (avail != '0);

    assign push = s_sc_send && (out_q != '0);
    assign drop = s_sc_send && (out_q == '0);
    assign pop  = (occ_q != '0) && m_tready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s_sc_req) begin
                    state_d = avail_nz ? GRANT : HOLD;
                end
            end
            GRANT: begin
                if (!s_sc_req) begin
                    state_d = IDLE;
                end else if (!avail_nz) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!s_sc_req) begin
                    state_d = IDLE;
                end else if (avail_nz) begin
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = (state_d == GRANT) && avail_nz;

    always_comb begin
        out_d = out_q;
        case ({grant, push})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge s_sc_aclk) begin
        if (s_sc_areset) begin
            state_q <= IDLE;
            recv_q  <= 1'b0;
            occ_q   <= '0;
            out_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            recv_q  <= grant;
            occ_q   <= occ_d;
            out_q   <= out_d;
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end

    sc_node_egress_ram #(
        .WIDTH (PAYLD_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (s_sc_aclk),
        .we_i    (push && !s_sc_areset),
        .waddr_i (wptr_q),
        .wdata_i ({s_sc_info, s_sc_payld}),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    assign s_sc_recv          = recv_q;
    assign m_tvalid           = (occ_q != '0);
    assign {m_tuser, m_tdata} = rd_data;
    assign outstanding        = out_q;
    assign occupancy          = occ_q;
    assign err_send_no_credit = err_q;

endmodule

// File: tb/tb_sc_node_egress.sv
// Self-checking bench for sc_node_egress: cycle vector table plus credit/stream scenarios.
module tb_sc_node_egress;
    import sc_node_pkg::*;

    localparam int PW    = SC_AR_W;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          areset;
    logic          req;
    logic          info;
    logic          send;
    logic [PW-1:0] payld;
    logic          recv;
    logic          tvalid;
    logic          tready;
    logic [PW-1:0] tdata;
    logic          tuser;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] occupancy;
    logic          err;

    always #5 clk = ~clk;

    sc_node_egress #(
        .PAYLD_WIDTH (PW),
        .DEPTH       (DEPTH)
    ) dut (
        .s_sc_aclk          (clk),
        .s_sc_areset        (areset),
        .s_sc_req           (req),
        .s_sc_info          (info),
        .s_sc_send          (send),
        .s_sc_payld         (payld),
        .s_sc_recv          (recv),
        .m_tvalid           (tvalid),
        .m_tready           (tready),
        .m_tdata            (tdata),
        .m_tuser            (tuser),
        .outstanding        (outstanding),
        .occupancy          (occupancy),
        .err_send_no_credit (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [PW:0] sb_q[$];
    int          credit_q[$];
    int          recv_log[$];
    int          pop_log[$];

    bit auto_en    = 1'b0;
    int lat        = 1;
    int sent_cnt   = 0;
    int send_limit = 1 << 30;
    int idx        = 0;

    typedef struct {
        bit req;
        bit send;
        bit rdy;
        bit exp_recv;
        bit exp_tvalid;
        int exp_occ;
        int exp_out;
        bit exp_err;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Samples the handshake and credit pulse mid-cycle, then advances one clock
    // and runs the sender model, which answers each credit after lat cycles.
    task automatic step();
        logic [PW:0] exp_w;
        @(negedge clk);
        if (recv) recv_log.push_back(cyc);
        if (tvalid && tready) begin
            pop_log.push_back(cyc);
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL pop_unexpected: got %h with nothing expected", {tuser, tdata});
            end else begin
                exp_w = sb_q.pop_front();
                if ({tuser, tdata} === exp_w) n_pass++;
                else $display("FAIL pop_data: got %h expected %h", {tuser, tdata}, exp_w);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        send = 1'b0;
        if (auto_en) begin
            if (credit_q.size() > 0 && sent_cnt < send_limit && cyc >= credit_q[0] + lat) begin
                void'(credit_q.pop_front());
                send  = 1'b1;
                payld = PW'(idx);
                info  = idx[0];
                sb_q.push_back({info, payld});
                idx++;
                sent_cnt++;
            end
            if (recv) credit_q.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        tready  = 1'b0;
        req     = 1'b0;
        auto_en = 1'b0;
        areset  = 1'b1;
        step();
        step();
        areset = 1'b0;
        sb_q.delete();
        credit_q.delete();
        recv_log.delete();
        pop_log.delete();
        idx        = 0;
        sent_cnt   = 0;
        send_limit = 1 << 30;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   t;
        int   p;
        int   gaps;

        areset = 1'b1;
        req    = 1'b0;
        info   = 1'b0;
        send   = 1'b0;
        payld  = '0;
        tready = 1'b0;

        do_reset();
        check("rst_recv", recv, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_err", err, 0);

        // req, send, rdy | recv, tvalid, occ, out, err (values after the edge)
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            req    = vt[i].req;
            tready = vt[i].rdy;
            if (vt[i].send) begin
                send  = 1'b1;
                payld = PW'(32'hA50 + i);
                info  = i[0];
                sb_q.push_back({info, payld});
            end
            step();
            check($sformatf("vec%0d_recv", i), recv, vt[i].exp_recv);
            check($sformatf("vec%0d_tvalid", i), tvalid, vt[i].exp_tvalid);
            check($sformatf("vec%0d_occ", i), occupancy, vt[i].exp_occ);
            check($sformatf("vec%0d_out", i), outstanding, vt[i].exp_out);
            check($sformatf("vec%0d_err", i), err, vt[i].exp_err);
        end
        tready = 1'b0;

        // Fill: eight back-to-back credits, then HOLD with a full buffer.
        do_reset();
        auto_en = 1'b1;
        lat     = 1;
        req     = 1'b1;
        t       = cyc;
        repeat (14) step();
        check("fill_recv_count", recv_log.size(), 8);
        for (int i = 0; i < 8 && i < recv_log.size(); i++)
            check($sformatf("fill_recv_cyc%0d", i), recv_log[i], t + 1 + i);
        check("fill_occ", occupancy, 8);
        check("fill_out", outstanding, 0);
        check("fill_state_hold", int'(dut.state_q), int'(HOLD));

        // Pop three; each freed slot is seen next cycle and granted at that edge.
        recv_log.delete();
        pop_log.delete();
        p      = cyc;
        tready = 1'b1;
        repeat (3) step();
        tready = 1'b0;
        repeat (8) step();
        check("pop3_count", pop_log.size(), 3);
        if (pop_log.size() > 0) check("pop3_first_cyc", pop_log[0], p);
        check("pop3_recv_count", recv_log.size(), 3);
        if (recv_log.size() > 0) check("pop3_first_recv", recv_log[0], p + 2);
        if (recv_log.size() > 2) check("pop3_last_recv", recv_log[2], p + 4);
        check("pop3_occ", occupancy, 8);
        check("pop3_out", outstanding, 0);
        req = 1'b0;

        // Stream 100 beats at full rate.
        do_reset();
        auto_en    = 1'b1;
        lat        = 1;
        send_limit = 100;
        tready     = 1'b1;
        req        = 1'b1;
        for (int k = 0; k < 400 && pop_log.size() < 100; k++) step();
        req = 1'b0;
        check("stream_pops", pop_log.size(), 100);
        gaps = 0;
        for (int i = 1; i < pop_log.size(); i++)
            if (pop_log[i] - pop_log[i-1] != 1) gaps++;
        check("stream_gaps", gaps, 0);
        check("stream_sb_left", sb_q.size(), 0);

        // Beat without credit is dropped and flagged.
        do_reset();
        tready = 1'b1;
        send   = 1'b1;
        payld  = '1;
        info   = 1'b1;
        step();
        check("nocred_err", err, 1);
        check("nocred_occ", occupancy, 0);
        check("nocred_out", outstanding, 0);
        check("nocred_tvalid", tvalid, 0);
        repeat (3) step();
        check("nocred_err_sticky", err, 1);
        auto_en    = 1'b1;
        lat        = 1;
        send_limit = 10;
        req        = 1'b1;
        for (int k = 0; k < 100 && pop_log.size() < 10; k++) step();
        req = 1'b0;
        check("nocred_stream_pops", pop_log.size(), 10);
        check("nocred_err_after", err, 1);

        // Four credits, req drops, beats come back five cycles later.
        do_reset();
        auto_en = 1'b1;
        lat     = 5;
        req     = 1'b1;
        repeat (4) step();
        req = 1'b0;
        step();
        check("late_out4", outstanding, 4);
        check("late_occ0", occupancy, 0);
        repeat (8) step();
        check("late_recv_count", recv_log.size(), 4);
        check("late_occ4", occupancy, 4);
        check("late_out0", outstanding, 0);
        check("late_state_idle", int'(dut.state_q), int'(IDLE));

        // Reset mid-operation with beats buffered and credits outstanding.
        do_reset();
        auto_en    = 1'b1;
        lat        = 1;
        send_limit = 5;
        req        = 1'b1;
        repeat (7) step();
        req = 1'b0;
        repeat (6) step();
        check("pre_rst_occ", occupancy, 5);
        check("pre_rst_out", outstanding, 2);
        auto_en = 1'b0;
        credit_q.delete();
        areset = 1'b1;
        send   = 1'b1;
        payld  = PW'(32'h77);
        step();
        check("mid_rst_recv", recv, 0);
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_out", outstanding, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_err", err, 0);
        send = 1'b1;
        step();
        check("mid_rst_send_err", err, 0);
        areset = 1'b0;
        sb_q.delete();
        step();
        check("post_rst_err", err, 0);
        check("post_rst_occ", occupancy, 0);
        check("post_rst_recv", recv, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
